// File: rtl/iob_bus_split_n_pkg.sv
// Shared definitions for the iob_bus_split_n native-bus splitter: FSM encodings,
// default error response data and the s_rdata channel slice helper.
package iob_bus_split_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } split_state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    // LSB index of slave channel ch inside the flattened s_rdata bus.
    function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/iob_bus_split_timer.sv
// Per-transaction timeout counter: cleared while clr_i is high, counts while en_i is
// high and saturates at TIMEOUT-1, where expired_o is asserted.
module iob_bus_split_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/iob_bus_split_n.sv
// Native-bus splitter: one registered master request is routed to one of N_SLAVES
// slave channels by address MSBs, with decode-error and timeout error responses.
module iob_bus_split_n
    import iob_bus_split_n_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         N_SLAVES = 4,
    parameter int unsigned         SEL_W    = 2,
    parameter int unsigned         TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0]   ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_ready,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    output logic                       err,
    output logic [ADDR_W-1:0]          err_addr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    split_state_e        state_q;
    logic [DATA_W-1:0]   m_rdata_q;
    logic                m_ready_q;
    logic [N_SLAVES-1:0] s_valid_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_wdata_q;
    logic [STRB_W-1:0]   s_wstrb_q;
    logic                err_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic [SEL_W-1:0]    m_sel;
    logic                sel_in_range;
    logic [N_SLAVES-1:0] sel_onehot;
    logic                slave_hit;
    logic                expired;
    logic [DATA_W-1:0]   rdata_sel;
    logic [DATA_W-1:0]   s_rdata_ch [N_SLAVES];

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_ch
        assign s_rdata_ch[gi] = s_rdata[chan_lsb(gi, DATA_W) +: DATA_W];
    end

    assign m_sel        = m_addr[ADDR_W-1 -: SEL_W];
    assign sel_in_range = (32'(m_sel) < N_SLAVES);
    assign sel_onehot   = N_SLAVES'(1) << m_sel;

    // s_valid_q is one-hot on the selected channel during REQ, so it doubles as the
    // response mux select and masks out s_ready from idle channels.
    assign slave_hit = |(s_ready & s_valid_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_valid_q[i]) begin
                rdata_sel = rdata_sel | s_rdata_ch[i];
            end
        end
    end

    if (TIMEOUT != 0) begin : g_timer
        iob_bus_split_timer #(
            .TIMEOUT(TIMEOUT)
        ) u_timer (
            .clk      (clk),
            .resetn   (resetn),
            .clr_i    (state_q != ST_REQ),
            .en_i     (state_q == ST_REQ),
            .expired_o(expired)
        );
    end else begin : g_no_timer
        assign expired = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            m_rdata_q  <= '0;
            m_ready_q  <= 1'b0;
            s_valid_q  <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            m_ready_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m_valid) begin
                        s_addr_q  <= m_addr;
                        s_wdata_q <= m_wdata;
                        s_wstrb_q <= m_wstrb;
                        if (sel_in_range) begin
                            s_valid_q <= sel_onehot;
                            state_q   <= ST_REQ;
                        end else begin
                            err_addr_q <= m_addr;
                            m_rdata_q  <= ERR_DATA;
                            m_ready_q  <= 1'b1;
                            err_q      <= 1'b1;
                            state_q    <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    // A response arriving in the expiry cycle still wins over the timeout.
                    if (slave_hit) begin
                        m_rdata_q <= rdata_sel;
                        m_ready_q <= 1'b1;
                        s_valid_q <= '0;
                        state_q   <= ST_RESP;
                    end else if (expired) begin
                        err_addr_q <= s_addr_q;
                        m_rdata_q  <= ERR_DATA;
                        m_ready_q  <= 1'b1;
                        err_q      <= 1'b1;
                        s_valid_q  <= '0;
                        state_q    <= ST_ERR;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_rdata  = m_rdata_q;
    assign m_ready  = m_ready_q;
    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule
